// File: rtl/latex_stream_engine.sv
// latex_stream_engine: maps a line index to a ROM span and streams its lhs/rhs character pairs over valid/ready.
// Optional callsign beacon is enabled by defining LATEX_STREAM_CALLSIGN_EN.
module latex_stream_engine #(
    parameter int ADDR_W = 10,
    parameter int LINE_W = 6,
    parameter int LEN_W  = 10,
    parameter int CHAR_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [LINE_W-1:0]     line,
    input  logic                  loop,
    input  logic                  beacon,
    output logic [LINE_W-1:0]     ptr_line,
    input  logic [ADDR_W-1:0]     ptr_base,
    input  logic [LEN_W-1:0]      ptr_len,
    output logic [ADDR_W-1:0]     mem_addr,
    input  logic [2*CHAR_W-1:0]   mem_dout,
    output logic [CHAR_W-1:0]     lhs,
    output logic [CHAR_W-1:0]     rhs,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  done,
    output logic [LEN_W-1:0]      chars_remaining
);

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        FETCH,
        LOAD,
        PRESENT,
        DONE
    } state_t;

    localparam logic [LEN_W-1:0] CALL_LEN = LEN_W'(12);

    state_t              state;
    logic                start_q;
    logic                start_edge;
    logic [ADDR_W-1:0]   base_r;
    logic [LEN_W-1:0]    len_r;
    logic                beacon_now;
    logic                beacon_on;
    logic [CHAR_W-1:0]   beacon_char;

    assign start_edge = start & ~start_q;

`ifdef LATEX_STREAM_CALLSIGN_EN
    localparam logic [95:0] CALLSIGN = "CQ DE KC1GPW";

    logic       beacon_r;
    logic [3:0] call_idx;

    // Beacon request is captured with the start edge and held for the whole run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beacon_r <= 1'b0;
        end else if (state == IDLE && start_edge) begin
            beacon_r <= beacon;
        end
    end

    assign beacon_now  = beacon;
    assign beacon_on   = beacon_r;
    assign call_idx    = 4'(CALL_LEN - chars_remaining);
    assign beacon_char = CHAR_W'(CALLSIGN[8*(4'd11 - call_idx) +: 8]);
`else
    wire unused_beacon = beacon;

    assign beacon_now  = 1'b0;
    assign beacon_on   = 1'b0;
    assign beacon_char = '0;
`endif

    // Main sequencer: lookup, fetch/load/present per pair, optional loop, done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            start_q         <= 1'b1;
            ptr_line        <= '0;
            base_r          <= '0;
            len_r           <= '0;
            mem_addr        <= '0;
            chars_remaining <= '0;
            lhs             <= '0;
            rhs             <= '0;
            out_valid       <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
        end else begin
            start_q <= start;
            done    <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start_edge) begin
                        if (!beacon_now) begin
                            ptr_line <= line;
                        end
                        busy  <= 1'b1;
                        state <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (beacon_on) begin
                        base_r          <= '0;
                        len_r           <= CALL_LEN;
                        chars_remaining <= CALL_LEN;
                        mem_addr        <= '0;
                        state           <= FETCH;
                    end else begin
                        base_r          <= ptr_base;
                        len_r           <= ptr_len;
                        chars_remaining <= ptr_len;
                        mem_addr        <= ptr_base;
                        if (ptr_len == '0) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            state <= FETCH;
                        end
                    end
                end
                FETCH: begin
                    state <= LOAD;
                end
                LOAD: begin
                    if (beacon_on) begin
                        lhs <= beacon_char;
                        rhs <= beacon_char;
                    end else begin
                        lhs <= mem_dout[2*CHAR_W-1:CHAR_W];
                        rhs <= mem_dout[CHAR_W-1:0];
                    end
                    out_valid <= 1'b1;
                    state     <= PRESENT;
                end
                PRESENT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (chars_remaining == LEN_W'(1) && loop) begin
                            mem_addr        <= base_r;
                            chars_remaining <= len_r;
                            state           <= FETCH;
                        end else begin
                            chars_remaining <= chars_remaining - LEN_W'(1);
                            if (!beacon_on) begin
                                mem_addr <= mem_addr + ADDR_W'(1);
                            end
                            if (chars_remaining == LEN_W'(1)) begin
                                done  <= 1'b1;
                                state <= DONE;
                            end else begin
                                state <= FETCH;
                            end
                        end
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_latex_stream_engine.sv
// tb_latex_stream_engine: directed stimulus with a queue scoreboard checked by an independent monitor.
// Models the line mapper (combinational from ptr_line) and a 1-cycle registered character ROM.
module tb_latex_stream_engine;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [5:0]  line = '0;
    logic        loop = 1'b0;
    logic        beacon = 1'b0;
    logic [5:0]  ptr_line;
    logic [9:0]  ptr_base;
    logic [9:0]  ptr_len;
    logic [9:0]  mem_addr;
    logic [15:0] mem_dout = '0;
    logic [7:0]  lhs;
    logic [7:0]  rhs;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        busy;
    logic        done;
    logic [9:0]  chars_remaining;

    latex_stream_engine dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .line(line),
        .loop(loop),
        .beacon(beacon),
        .ptr_line(ptr_line),
        .ptr_base(ptr_base),
        .ptr_len(ptr_len),
        .mem_addr(mem_addr),
        .mem_dout(mem_dout),
        .lhs(lhs),
        .rhs(rhs),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .busy(busy),
        .done(done),
        .chars_remaining(chars_remaining)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] l;
        logic [7:0] r;
        logic [9:0] rem;
    } exp_t;

    exp_t        exp_q[$];
    int          hs_times[$];
    logic [15:0] rom [0:1023];
    logic [9:0]  base_tab [0:63];
    logic [9:0]  len_tab [0:63];

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int hs_cnt = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int vcnt = 0;

    function automatic logic [15:0] romv(input int a);
        logic [7:0] hi;
        logic [7:0] lo;
        hi = 8'(a ^ 'h5A);
        lo = 8'(a >> 2);
        return {hi, lo};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic push(input logic [15:0] p, input int rem);
        exp_t e;
        e.l = p[15:8];
        e.r = p[7:0];
        e.rem = 10'(rem);
        exp_q.push_back(e);
    endtask

    // ROM and mapper models
    always @(posedge clk) mem_dout <= rom[mem_addr];
    assign ptr_base = base_tab[ptr_line];
    assign ptr_len  = len_tab[ptr_line];

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pops the scoreboard on every handshake
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid) vcnt++;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (out_valid && out_ready) begin
                exp_t e;
                hs_cnt++;
                hs_times.push_back(cyc);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pair: got %0h/%0h expected none", lhs, rhs);
                end else begin
                    e = exp_q.pop_front();
                    chk("pair_lhs", 32'(lhs), 32'(e.l));
                    chk("pair_rhs", 32'(rhs), 32'(e.r));
                    chk("pair_rem", 32'(chars_remaining), 32'(e.rem));
                end
            end
        end
    end

    task automatic pulse_start(input logic [5:0] ln, input logic b, output int t0);
        @(posedge clk);
        #1;
        line = ln;
        beacon = b;
        start = 1'b1;
        t0 = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int d0;
        int n;
        d0 = done_cnt;
        n = 0;
        while (done_cnt == d0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (done_cnt == d0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done expected done within %0d", budget);
        end
    endtask

    task automatic wait_hs(input int target, input int budget);
        int n;
        n = 0;
        while (hs_cnt < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (hs_cnt < target) begin
            checks++;
            errors++;
            $display("FAIL hs_timeout: got %0d expected %0d", hs_cnt, target);
        end
    endtask

    task automatic wait_present(input int rem, input int budget);
        int n;
        n = 0;
        @(negedge clk);
        while (!(out_valid && chars_remaining == 10'(rem)) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!(out_valid && chars_remaining == 10'(rem))) begin
            checks++;
            errors++;
            $display("FAIL present_timeout: got rem %0d expected %0d", chars_remaining, rem);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int t0;
        int tx;
        int h0;
        int d0;
        int vc0;
        logic [7:0] sl;
        logic [7:0] sr;
        logic [9:0] sa;
        string cs;

        for (int i = 0; i < 1024; i++) rom[i] = romv(i);
        for (int i = 0; i < 64; i++) begin
            base_tab[i] = '0;
            len_tab[i] = '0;
        end
        base_tab[5] = 10'h100; len_tab[5] = 10'd3;
        base_tab[6] = 10'h3FF; len_tab[6] = 10'd2;
        base_tab[7] = 10'h000; len_tab[7] = 10'd0;
        base_tab[8] = 10'h200; len_tab[8] = 10'd2;
        base_tab[9] = 10'h010; len_tab[9] = 10'd12;

        // reset with start held high
        rst_n = 1'b0;
        start = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_rem", 32'(chars_remaining), 0);
        chk("rst_addr", 32'(mem_addr), 0);
        chk("rst_line", 32'(ptr_line), 0);
        chk("rst_lhs", 32'(lhs), 0);
        chk("rst_rhs", 32'(rhs), 0);
        @(posedge clk);
        #1 start = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_no_pass", 32'(busy), 0);

        // basic pass, line 5, timing
        for (int i = 0; i < 3; i++) push(romv('h100 + i), 3 - i);
        hs_times.delete();
        pulse_start(6'd5, 1'b0, t0);
        @(negedge clk);
        chk("busy_lookup", 32'(busy), 1);
        wait_done(100);
        chk("n_hs", 32'(hs_times.size()), 3);
        if (hs_times.size() >= 3) begin
            chk("t_pair0", 32'(hs_times[0] - t0), 4);
            chk("t_pair1", 32'(hs_times[1] - t0), 7);
            chk("t_pair2", 32'(hs_times[2] - t0), 10);
        end
        chk("t_done", 32'(done_cyc - t0), 11);
        repeat (2) @(negedge clk);
        chk("idle_busy", 32'(busy), 0);
        chk("end_rem", 32'(chars_remaining), 0);
        chk("hold_lhs", 32'(lhs), 32'(8'(romv('h102) >> 8)));
        chk("ptr_line5", 32'(ptr_line), 5);

        // backpressure on the second pair
        for (int i = 0; i < 3; i++) push(romv('h100 + i), 3 - i);
        pulse_start(6'd5, 1'b0, t0);
        wait_present(3, 50);
        @(posedge clk);
        #1 out_ready = 1'b0;
        wait_present(2, 50);
        sl = lhs;
        sr = rhs;
        sa = mem_addr;
        chk("bp_addr", 32'(mem_addr), 32'h101);
        repeat (5) begin
            @(negedge clk);
            chk("bp_valid", 32'(out_valid), 1);
            chk("bp_lhs", 32'(lhs), 32'(sl));
            chk("bp_rhs", 32'(rhs), 32'(sr));
            chk("bp_maddr", 32'(mem_addr), 32'(sa));
            chk("bp_rem", 32'(chars_remaining), 2);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        wait_done(100);

        // address wrap
        push(romv('h3FF), 2);
        push(romv('h000), 1);
        pulse_start(6'd6, 1'b0, t0);
        wait_done(100);
        @(negedge clk);
        chk("wrap_addr", 32'(mem_addr), 32'h001);

        // empty line
        vc0 = vcnt;
        pulse_start(6'd7, 1'b0, t0);
        wait_done(50);
        chk("empty_done_t", 32'(done_cyc - t0), 2);
        chk("empty_novalid", 32'(vcnt), 32'(vc0));

        // loop mode with ignored mid-pass start
        loop = 1'b1;
        push(romv('h200), 2);
        push(romv('h201), 1);
        push(romv('h200), 2);
        push(romv('h201), 1);
        h0 = hs_cnt;
        d0 = done_cnt;
        pulse_start(6'd8, 1'b0, t0);
        wait_hs(h0 + 1, 50);
        pulse_start(6'd5, 1'b0, tx);
        wait_hs(h0 + 3, 50);
        chk("loop_nodone", 32'(done_cnt), 32'(d0));
        @(posedge clk);
        #1 loop = 1'b0;
        wait_done(100);
        chk("loop_hs", 32'(hs_cnt), 32'(h0 + 4));
        chk("loop_done_t", 32'(done_cyc - hs_times[hs_times.size() - 1]), 1);
        chk("loop_line", 32'(ptr_line), 8);

        // beacon request
        cs = "CQ DE KC1GPW";
`ifdef LATEX_STREAM_CALLSIGN_EN
        for (int i = 0; i < 12; i++) push({cs[i], cs[i]}, 12 - i);
`else
        for (int i = 0; i < 12; i++) push(romv('h010 + i), 12 - i);
`endif
        pulse_start(6'd9, 1'b1, t0);
        wait_done(300);
        @(negedge clk);
`ifdef LATEX_STREAM_CALLSIGN_EN
        chk("bcn_line", 32'(ptr_line), 8);
        chk("bcn_addr", 32'(mem_addr), 0);
`else
        chk("bcn_line", 32'(ptr_line), 9);
        chk("bcn_addr", 32'(mem_addr), 32'h01C);
`endif
        beacon = 1'b0;

        repeat (3) @(negedge clk);
        chk("sb_empty", 32'(exp_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
